// File: rtl/eth_type_demux.sv
// eth_type_demux
//   EtherType demultiplexer for the Ethernet RX path. Each frame (header plus
//   8-bit payload stream) is routed to one of M_COUNT outputs by comparing
//   s_eth_type against a per-output match table. Frames that match no enabled
//   entry are consumed and dropped, with a one-cycle drop_frame pulse.
//
// Parameters
//   M_COUNT    number of output channels (1..16)
//   M_TYPE     packed EtherType table, slice i = type routed to output i
//   CNT_WIDTH  width of the statistics counters
//
// Ports
//   clk, rst                         clock, asynchronous active-high reset
//   enable[M_COUNT]                  per-channel match enable, sampled at header handshake
//   s_eth_hdr_*                      input header (valid/ready, MACs, type)
//   s_eth_payload_axis_*             input payload stream
//   m_eth_hdr_valid/ready[M_COUNT]   per-channel header handshake
//   m_eth_dest_mac/src_mac/type      registered header, shared by all channels
//   m_eth_payload_axis_tvalid/tready per-channel payload handshake
//   m_eth_payload_axis_tdata/tlast/tuser  shared payload bus (pass-through)
//   drop_frame                       one-cycle pulse per dropped frame
//   busy                             high while a frame is in progress
//   stat_frame_count, stat_drop_count  statistics counters
//
// Configuration
//   ETH_TYPE_DEMUX_STATS_EN  when defined, builds per-channel routed-frame
//   counters and a dropped-frame counter (wrapping). When undefined the stat
//   ports are tied to zero.

module eth_type_demux #(
  parameter int                    M_COUNT   = 2,
  parameter logic [M_COUNT*16-1:0] M_TYPE    = {16'h0806, 16'h0800},
  parameter int                    CNT_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [M_COUNT-1:0]             enable,

  input  logic                           s_eth_hdr_valid,
  output logic                           s_eth_hdr_ready,
  input  logic [47:0]                    s_eth_dest_mac,
  input  logic [47:0]                    s_eth_src_mac,
  input  logic [15:0]                    s_eth_type,
  input  logic [7:0]                     s_eth_payload_axis_tdata,
  input  logic                           s_eth_payload_axis_tvalid,
  output logic                           s_eth_payload_axis_tready,
  input  logic                           s_eth_payload_axis_tlast,
  input  logic                           s_eth_payload_axis_tuser,

  output logic [M_COUNT-1:0]             m_eth_hdr_valid,
  input  logic [M_COUNT-1:0]             m_eth_hdr_ready,
  output logic [47:0]                    m_eth_dest_mac,
  output logic [47:0]                    m_eth_src_mac,
  output logic [15:0]                    m_eth_type,
  output logic [M_COUNT-1:0]             m_eth_payload_axis_tvalid,
  input  logic [M_COUNT-1:0]             m_eth_payload_axis_tready,
  output logic [7:0]                     m_eth_payload_axis_tdata,
  output logic                           m_eth_payload_axis_tlast,
  output logic                           m_eth_payload_axis_tuser,

  output logic                           drop_frame,
  output logic                           busy,
  output logic [M_COUNT*CNT_WIDTH-1:0]   stat_frame_count,
  output logic [CNT_WIDTH-1:0]           stat_drop_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    DROP    = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [M_COUNT-1:0]   sel_oh_q, sel_oh_d;       // one-hot selected channel
  logic [M_COUNT-1:0]   hdr_valid_q, hdr_valid_d;
  logic [47:0]          dest_q, dest_d;
  logic [47:0]          src_q, src_d;
  logic [15:0]          type_q, type_d;
  logic                 drop_q, drop_d;

  logic [M_COUNT-1:0]   match_oh;                 // lowest matching enabled entry
  logic [M_COUNT-1:0]   route_hs;                 // header accepted and routed this cycle

  // Scan from the top down so the lowest index is written last and wins
  // when the table holds duplicate types.
  always_comb begin
    match_oh = '0;
    for (int i = M_COUNT - 1; i >= 0; i--) begin
      if (enable[i] && (s_eth_type == M_TYPE[i*16 +: 16])) begin
        match_oh    = '0;
        match_oh[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_oh_q    <= '0;
      hdr_valid_q <= '0;
      dest_q      <= '0;
      src_q       <= '0;
      type_q      <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_oh_q    <= sel_oh_d;
      hdr_valid_q <= hdr_valid_d;
      dest_q      <= dest_d;
      src_q       <= src_d;
      type_q      <= type_d;
      drop_q      <= drop_d;
    end
  end

  always_comb begin
    state_d                   = state_q;
    sel_oh_d                  = sel_oh_q;
    dest_d                    = dest_q;
    src_d                     = src_q;
    type_d                    = type_q;
    drop_d                    = 1'b0;
    route_hs                  = '0;
    s_eth_hdr_ready           = 1'b0;
    s_eth_payload_axis_tready = 1'b0;
    m_eth_payload_axis_tvalid = '0;

    case (state_q)
      IDLE: begin
        // A header still waiting downstream holds off the next frame, since
        // the header registers are shared by all channels.
        s_eth_hdr_ready = ~(|hdr_valid_q);
        if (s_eth_hdr_valid && s_eth_hdr_ready) begin
          if (|match_oh) begin
            route_hs = match_oh;
            sel_oh_d = match_oh;
            dest_d   = s_eth_dest_mac;
            src_d    = s_eth_src_mac;
            type_d   = s_eth_type;
            state_d  = PAYLOAD;
          end else begin
            drop_d  = 1'b1;
            state_d = DROP;
          end
        end
      end
      PAYLOAD: begin
        m_eth_payload_axis_tvalid = sel_oh_q & {M_COUNT{s_eth_payload_axis_tvalid}};
        s_eth_payload_axis_tready = |(sel_oh_q & m_eth_payload_axis_tready);
        if (s_eth_payload_axis_tvalid && s_eth_payload_axis_tready &&
            s_eth_payload_axis_tlast) begin
          state_d = IDLE;
        end
      end
      DROP: begin
        s_eth_payload_axis_tready = 1'b1;
        if (s_eth_payload_axis_tvalid && s_eth_payload_axis_tlast) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    hdr_valid_d = (hdr_valid_q & ~m_eth_hdr_ready) | route_hs;
  end

  assign m_eth_hdr_valid          = hdr_valid_q;
  assign m_eth_dest_mac           = dest_q;
  assign m_eth_src_mac            = src_q;
  assign m_eth_type               = type_q;
  assign m_eth_payload_axis_tdata = s_eth_payload_axis_tdata;
  assign m_eth_payload_axis_tlast = s_eth_payload_axis_tlast;
  assign m_eth_payload_axis_tuser = s_eth_payload_axis_tuser;
  assign drop_frame               = drop_q;
  assign busy                     = (state_q != IDLE);

`ifdef ETH_TYPE_DEMUX_STATS_EN
  logic [CNT_WIDTH-1:0] frame_cnt_q [M_COUNT];
  logic [CNT_WIDTH-1:0] drop_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < M_COUNT; i++) frame_cnt_q[i] <= '0;
      drop_cnt_q <= '0;
    end else begin
      for (int i = 0; i < M_COUNT; i++) begin
        if (route_hs[i]) frame_cnt_q[i] <= frame_cnt_q[i] + CNT_WIDTH'(1);
      end
      if (drop_q) drop_cnt_q <= drop_cnt_q + CNT_WIDTH'(1);
    end
  end

  for (genvar g = 0; g < M_COUNT; g++) begin : g_stat
    assign stat_frame_count[g*CNT_WIDTH +: CNT_WIDTH] = frame_cnt_q[g];
  end
  assign stat_drop_count = drop_cnt_q;
`else
  assign stat_frame_count = '0;
  assign stat_drop_count  = '0;
`endif

endmodule

// File: tb/tb_eth_type_demux.sv
// Directed bench for eth_type_demux: a default two-channel instance (IPv4 on
// channel 0, ARP on channel 1) and a three-channel instance with a duplicate
// table entry.
module tb_eth_type_demux;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Two-channel instance
  logic [1:0]  enable;
  logic        s_hdr_valid, s_hdr_ready;
  logic [47:0] s_dest, s_src;
  logic [15:0] s_type;
  logic [7:0]  s_tdata;
  logic        s_tvalid, s_tready, s_tlast, s_tuser;
  logic [1:0]  m_hdr_valid, m_hdr_ready;
  logic [47:0] m_dest, m_src;
  logic [15:0] m_type;
  logic [1:0]  m_tvalid, m_tready;
  logic [7:0]  m_tdata;
  logic        m_tlast, m_tuser;
  logic        drop, busy;
  logic [63:0] stat_fc;
  logic [31:0] stat_dc;

  eth_type_demux dut (
    .clk(clk), .rst(rst), .enable(enable),
    .s_eth_hdr_valid(s_hdr_valid), .s_eth_hdr_ready(s_hdr_ready),
    .s_eth_dest_mac(s_dest), .s_eth_src_mac(s_src), .s_eth_type(s_type),
    .s_eth_payload_axis_tdata(s_tdata), .s_eth_payload_axis_tvalid(s_tvalid),
    .s_eth_payload_axis_tready(s_tready), .s_eth_payload_axis_tlast(s_tlast),
    .s_eth_payload_axis_tuser(s_tuser),
    .m_eth_hdr_valid(m_hdr_valid), .m_eth_hdr_ready(m_hdr_ready),
    .m_eth_dest_mac(m_dest), .m_eth_src_mac(m_src), .m_eth_type(m_type),
    .m_eth_payload_axis_tvalid(m_tvalid), .m_eth_payload_axis_tready(m_tready),
    .m_eth_payload_axis_tdata(m_tdata), .m_eth_payload_axis_tlast(m_tlast),
    .m_eth_payload_axis_tuser(m_tuser),
    .drop_frame(drop), .busy(busy),
    .stat_frame_count(stat_fc), .stat_drop_count(stat_dc)
  );

  // Three-channel instance: slice0=0x0800, slice1=0x0806, slice2=0x0800
  logic [2:0]  b_enable;
  logic        b_s_hdr_valid, b_s_hdr_ready;
  logic [15:0] b_s_type;
  logic        b_s_tvalid, b_s_tready, b_s_tlast;
  logic [2:0]  b_m_hdr_valid, b_m_tvalid;
  logic [47:0] b_m_dest, b_m_src;
  logic [15:0] b_m_type;
  logic [7:0]  b_m_tdata;
  logic        b_m_tlast, b_m_tuser, b_drop, b_busy;
  logic [95:0] b_stat_fc;
  logic [31:0] b_stat_dc;

  eth_type_demux #(
    .M_COUNT(3),
    .M_TYPE({16'h0800, 16'h0806, 16'h0800})
  ) dut3 (
    .clk(clk), .rst(rst), .enable(b_enable),
    .s_eth_hdr_valid(b_s_hdr_valid), .s_eth_hdr_ready(b_s_hdr_ready),
    .s_eth_dest_mac(48'h0), .s_eth_src_mac(48'h0), .s_eth_type(b_s_type),
    .s_eth_payload_axis_tdata(8'h5A), .s_eth_payload_axis_tvalid(b_s_tvalid),
    .s_eth_payload_axis_tready(b_s_tready), .s_eth_payload_axis_tlast(b_s_tlast),
    .s_eth_payload_axis_tuser(1'b0),
    .m_eth_hdr_valid(b_m_hdr_valid), .m_eth_hdr_ready(3'b111),
    .m_eth_dest_mac(b_m_dest), .m_eth_src_mac(b_m_src), .m_eth_type(b_m_type),
    .m_eth_payload_axis_tvalid(b_m_tvalid), .m_eth_payload_axis_tready(3'b111),
    .m_eth_payload_axis_tdata(b_m_tdata), .m_eth_payload_axis_tlast(b_m_tlast),
    .m_eth_payload_axis_tuser(b_m_tuser),
    .drop_frame(b_drop), .busy(b_busy),
    .stat_frame_count(b_stat_fc), .stat_drop_count(b_stat_dc)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a header on the two-channel instance for exactly one cycle
  // (caller guarantees s_hdr_ready is high).
  task automatic offer_hdr(input logic [15:0] t, input logic [47:0] d, input logic [47:0] s);
    s_hdr_valid = 1'b1;
    s_type      = t;
    s_dest      = d;
    s_src       = s;
    tick();
    s_hdr_valid = 1'b0;
  endtask

  // Stream n beats onto the selected channel ch (ready assumed high).
  task automatic stream(input string tag, input int n, input logic [7:0] base,
                        input logic [1:0] exp_vld);
    for (int b = 0; b < n; b++) begin
      s_tdata  = base + 8'(b);
      s_tvalid = 1'b1;
      s_tlast  = (b == n - 1);
      s_tuser  = (b == n - 1);
      #1;
      chk({tag, "_tvalid"}, m_tvalid, exp_vld);
      chk({tag, "_tdata"},  m_tdata,  base + 8'(b));
      chk({tag, "_tready"}, s_tready, 1'b1);
      tick();
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    enable = 2'b11;
    s_hdr_valid = 0; s_dest = '0; s_src = '0; s_type = '0;
    s_tdata = '0; s_tvalid = 0; s_tlast = 0; s_tuser = 0;
    m_hdr_ready = 2'b11; m_tready = 2'b11;
    b_enable = 3'b110; b_s_hdr_valid = 0; b_s_type = '0;
    b_s_tvalid = 0; b_s_tlast = 0;

    // Reset state
    tick(); tick();
    chk("rst_hdr_valid", m_hdr_valid, 2'b00);
    chk("rst_tvalid",    m_tvalid,    2'b00);
    chk("rst_busy",      busy,        1'b0);
    chk("rst_drop",      drop,        1'b0);
    chk("rst_type",      m_type,      16'h0);
    chk("rst_hdr_ready", s_hdr_ready, 1'b1);
    rst = 1'b0;
    tick();

    // IPv4 frame, 20 bytes, everything ready
    offer_hdr(16'h0800, 48'h0011_2233_4455, 48'hAABB_CCDD_EEFF);
    chk("ip_hdr_valid", m_hdr_valid, 2'b01);
    chk("ip_type",      m_type,      16'h0800);
    chk("ip_dest",      m_dest,      48'h0011_2233_4455);
    chk("ip_src",       m_src,       48'hAABB_CCDD_EEFF);
    chk("ip_busy",      busy,        1'b1);
    chk("ip_hdr_ready_busy", s_hdr_ready, 1'b0);
    for (int b = 0; b < 20; b++) begin
      s_tdata = 8'h10 + 8'(b); s_tvalid = 1'b1; s_tlast = (b == 19); s_tuser = (b == 19);
      #1;
      chk("ip_tvalid", m_tvalid, 2'b01);
      chk("ip_tdata",  m_tdata,  8'h10 + 8'(b));
      chk("ip_tlast",  m_tlast,  (b == 19));
      chk("ip_tuser",  m_tuser,  (b == 19));
      tick();
    end
    s_tvalid = 0; s_tlast = 0; s_tuser = 0;
    chk("ip_busy_end",     busy,        1'b0);
    chk("ip_hdr_released", m_hdr_valid, 2'b00);

    // Unknown type 0x86DD, 10 bytes: dropped
    offer_hdr(16'h86DD, 48'h1, 48'h2);
    for (int b = 0; b < 10; b++) begin
      s_tdata = 8'(b); s_tvalid = 1'b1; s_tlast = (b == 9);
      #1;
      chk("drop_pulse",     drop,        (b == 0));
      chk("drop_tvalid",    m_tvalid,    2'b00);
      chk("drop_hdr_valid", m_hdr_valid, 2'b00);
      chk("drop_tready",    s_tready,    1'b1);
      chk("drop_busy",      busy,        1'b1);
      tick();
    end
    s_tvalid = 0; s_tlast = 0;
    chk("drop_busy_end", busy, 1'b0);
    chk("drop_type_kept", m_type, 16'h0800);

    // ARP on channel 1 with its header ready held low
    m_hdr_ready = 2'b01;
    offer_hdr(16'h0806, 48'h3, 48'h4);
    chk("arp_hdr_valid", m_hdr_valid, 2'b10);
    stream("arp", 5, 8'hA0, 2'b10);
    chk("arp_busy_end", busy, 1'b0);
    s_hdr_valid = 1'b1; s_type = 16'h0800; s_dest = 48'h5; s_src = 48'h6;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stall_hdr_ready", s_hdr_ready, 1'b0);
      chk("stall_hdr_valid", m_hdr_valid, 2'b10);
      chk("stall_busy",      busy,        1'b0);
      tick();
    end
    m_hdr_ready = 2'b11;
    tick();
    chk("stall_cleared",   m_hdr_valid, 2'b00);
    chk("stall_ready_up",  s_hdr_ready, 1'b1);
    tick();
    s_hdr_valid = 1'b0;
    chk("stall_accepted",  m_hdr_valid, 2'b01);
    chk("stall_type",      m_type,      16'h0800);
    chk("stall_busy2",     busy,        1'b1);

    // Downstream backpressure on the selected channel
    m_tready = 2'b10;
    s_tdata = 8'hC3; s_tvalid = 1'b1; s_tlast = 1'b1;
    #1;
    chk("bp_tready", s_tready, 1'b0);
    chk("bp_tvalid", m_tvalid, 2'b01);
    tick();
    chk("bp_busy_hold", busy, 1'b1);
    m_tready = 2'b11;
    #1;
    chk("bp_release", s_tready, 1'b1);
    tick();
    s_tvalid = 0; s_tlast = 0;
    chk("bp_busy_end", busy, 1'b0);

`ifdef ETH_TYPE_DEMUX_STATS_EN
    chk("stat_ch0",  stat_fc[31:0],  32'd2);
    chk("stat_ch1",  stat_fc[63:32], 32'd1);
    chk("stat_drop", stat_dc,        32'd1);
`else
    chk("stat_fc_tied", stat_fc, 64'd0);
    chk("stat_dc_tied", stat_dc, 32'd0);
`endif

    // Reset on beat 3 of an 8-byte ARP frame
    offer_hdr(16'h0806, 48'h7, 48'h8);
    for (int b = 0; b < 2; b++) begin
      s_tdata = 8'(b); s_tvalid = 1'b1; s_tlast = 1'b0;
      tick();
    end
    s_tdata = 8'h02;
    #1;
    chk("mid_tvalid_pre", m_tvalid, 2'b10);
    rst = 1'b1;
    #1;
    chk("mid_rst_tvalid",    m_tvalid,    2'b00);
    chk("mid_rst_hdr_valid", m_hdr_valid, 2'b00);
    chk("mid_rst_busy",      busy,        1'b0);
    chk("mid_rst_type",      m_type,      16'h0);
    s_tvalid = 1'b0;
    tick();
    chk("mid_rst_drop",      drop,        1'b0);
    rst = 1'b0;
    tick();
    offer_hdr(16'h0800, 48'h9, 48'hA);
    chk("post_rst_hdr_valid", m_hdr_valid, 2'b01);
    chk("post_rst_dest",      m_dest,      48'h9);
    stream("post", 2, 8'h40, 2'b01);
    chk("post_rst_busy_end",  busy,        1'b0);
`ifdef ETH_TYPE_DEMUX_STATS_EN
    chk("post_stat_ch0",  stat_fc[31:0],  32'd1);
    chk("post_stat_ch1",  stat_fc[63:32], 32'd0);
    chk("post_stat_drop", stat_dc,        32'd0);
`endif

    // Disabled channel never matches
    enable = 2'b10;
    offer_hdr(16'h0800, 48'hB, 48'hC);
    chk("dis_drop",      drop,        1'b1);
    chk("dis_hdr_valid", m_hdr_valid, 2'b00);
    s_tvalid = 1'b1; s_tlast = 1'b1;
    tick();
    s_tvalid = 0; s_tlast = 0;
    chk("dis_busy_end", busy, 1'b0);
    enable = 2'b11;

    // Three-channel instance: enable=110, type 0x0800 -> channel 2
    b_enable = 3'b110; b_s_type = 16'h0800; b_s_hdr_valid = 1'b1;
    tick();
    b_s_hdr_valid = 1'b0;
    chk("m3_route2_hdr", b_m_hdr_valid, 3'b100);
    b_s_tvalid = 1'b1; b_s_tlast = 1'b1;
    #1;
    chk("m3_route2_tvalid", b_m_tvalid, 3'b100);
    tick();
    b_s_tvalid = 0; b_s_tlast = 0;
    chk("m3_route2_idle", b_busy, 1'b0);

    // Duplicate entries: lowest index wins
    b_enable = 3'b111; b_s_hdr_valid = 1'b1;
    tick();
    b_s_hdr_valid = 1'b0;
    chk("m3_dup_hdr", b_m_hdr_valid, 3'b001);
    b_s_tvalid = 1'b1; b_s_tlast = 1'b1;
    #1;
    chk("m3_dup_tvalid", b_m_tvalid, 3'b001);
    tick();
    b_s_tvalid = 0; b_s_tlast = 0;

    // ARP with its channel disabled -> dropped
    b_enable = 3'b101; b_s_type = 16'h0806; b_s_hdr_valid = 1'b1;
    tick();
    b_s_hdr_valid = 1'b0;
    chk("m3_drop_pulse", b_drop,        1'b1);
    chk("m3_drop_hdr",   b_m_hdr_valid, 3'b000);
    b_s_tvalid = 1'b1; b_s_tlast = 1'b1;
    #1;
    chk("m3_drop_tready", b_s_tready, 1'b1);
    tick();
    b_s_tvalid = 0; b_s_tlast = 0;
    chk("m3_drop_idle", b_busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
